// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, slot encoding and FIFO entry layout for the frame buffer arbiter
package fb_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int H_ACT      = 640;
    localparam int V_ACT      = 480;
    localparam int SRC_W      = 320;
    typedef enum logic [1:0] {IDLE, RD, WR} slot_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_entry_t;
    function automatic logic [ADDR_W-1:0] src_addr(input logic [8:0] v, input logic [8:0] h);
        return (ADDR_W'(v) << 8) + (ADDR_W'(v) << 6) + ADDR_W'(h);
    endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: small synchronous FIFO holding camera pixels until a write slot frees up
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     CLK25,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  fb_entry_t                din,
    output fb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fb_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];
    // storage carries no reset: only entries between the pointers are ever read
    always_ff @(posedge CLK25)
        if (push)
            mem[wr_ptr] <= din;
    // pointers and occupancy; the arbiter never pushes when full nor pops when empty
    always_ff @(posedge CLK25 or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: time-slot sharing of the frame buffer RAM between camera writes and 2x-upscaled VGA reads
module fb_arbiter
    import fb_pkg::*;
(
    input  logic              CLK25,
    input  logic              reset,
    input  logic [10:0]       hcnt,
    input  logic [10:0]       vcnt,
    input  logic              cam_valid,
    output logic              cam_ready,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              ovf,
    input  logic              ovf_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    slot_t             state;
    slot_t             state_nxt;
    fb_entry_t         head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              rdy_en;
    logic              act;
    logic              act_q1;
    logic              act_q2;
    logic              rd_q;
    logic              push;
    logic              pop;
    logic              drop;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    assign act       = hcnt < 11'(H_ACT) && vcnt < 11'(V_ACT);
    assign cam_ready = rdy_en && count != CW'(FIFO_DEPTH);
    assign push      = cam_valid && cam_ready;
    assign drop      = cam_valid && (full || !rdy_en);
    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK25 (CLK25),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({cam_addr, cam_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // slot choice: even active pixels always read, every other cycle drains the FIFO if it can
    always_comb begin
        state_nxt     = IDLE;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        pop           = 1'b0;
        if (act && !hcnt[0]) begin
            state_nxt    = RD;
            mem_addr_nxt = src_addr(vcnt[9:1], hcnt[9:1]);
        end else if (!empty) begin
            state_nxt     = WR;
            mem_addr_nxt  = head.addr;
            mem_wdata_nxt = head.data;
            pop           = 1'b1;
        end
    end
    // slot register and RAM port: every RAM-facing signal leaves from a flop
    always_ff @(posedge CLK25 or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= state_nxt == WR;
        end
    // display pipeline: act and read-slot flags track the RAM latency so pixels line up with the scan
    always_ff @(posedge CLK25 or negedge reset)
        if (!reset) begin
            act_q1    <= 1'b0;
            act_q2    <= 1'b0;
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            act_q1    <= act;
            act_q2    <= act_q1;
            rd_q      <= state == RD;
            pix_valid <= act_q2;
            pix_data  <= !act_q2 ? '0 : rd_q ? mem_rdata : pix_data;
        end
    // camera side: ready opens one clock after reset release; a drop is remembered until cleared
    always_ff @(posedge CLK25 or negedge reset)
        if (!reset) begin
            rdy_en <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            ovf    <= drop || (ovf && !ovf_clr);
        end
endmodule
